// File: rtl/dec_lut_pkg.sv
// -----------------------------------------------------------------------------
// dec_lut_pkg
// Shared definitions for the 8-bit LUT decoder and its triangular-number
// encoder (dec_lut_encoder8bits_clk).
//
// Contents:
//   W_BITS   - default codeword width (holds 511*512/2 = 130816 < 2^20)
//   N_BITS   - default index width
//   state_t  - encoder control FSM states (IDLE, RUN, DONE)
//   tri_num  - constant-style helper giving N*(N+1)/2, for use by the decoder
//              side when it builds its lookup contents
// -----------------------------------------------------------------------------
package dec_lut_pkg;

    localparam int W_BITS = 20;
    localparam int N_BITS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [W_BITS-1:0] tri_num(input logic [N_BITS-1:0] n);
        logic [W_BITS-1:0] n_ext;
        logic [W_BITS-1:0] prod;
        n_ext = W_BITS'(n);
        prod  = n_ext * (n_ext + W_BITS'(1));
        return prod >> 1;
    endfunction

endpackage : dec_lut_pkg

// File: rtl/dec_lut_encoder8bits_clk.sv
// -----------------------------------------------------------------------------
// dec_lut_encoder8bits_clk
// Sequential encoder producing the triangular number W = N*(N+1)/2, the
// inverse of the team's 8-bit LUT decoder. The sum 1+2+...+N is built with
// one addition per clock, so an index k completes k+1 cycles after the edge
// that accepted the request.
//
// Parameters:
//   W_BITS  codeword width (default 20)
//   N_BITS  index width    (default 9)
//
// Ports:
//   clk    in   single clock, rising-edge
//   rst_n  in   asynchronous active-low reset
//   start  in   encode request, sampled in IDLE or DONE
//   N      in   index, captured only when a request is accepted
//   busy   out  high while an encode is running
//   done   out  one-cycle pulse, W holds a new result
//   W      out  registered codeword, held until the next completion
// -----------------------------------------------------------------------------
module dec_lut_encoder8bits_clk #(
    parameter int W_BITS = dec_lut_pkg::W_BITS,
    parameter int N_BITS = dec_lut_pkg::N_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] N,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] W
);

    import dec_lut_pkg::*;

    state_t              state;
    state_t              state_next;
    logic                armed;
    logic                accept;
    logic                finish;
    logic [N_BITS-1:0]   n_reg;
    logic [N_BITS-1:0]   cnt;
    logic [W_BITS-1:0]   acc;
    logic [W_BITS-1:0]   w_reg;

    // The first rising edge after reset release only arms the block, so a
    // start that coincides with the release edge can never begin an encode
    // regardless of how the release lines up with the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    assign finish = (state == RUN) && (cnt == n_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE accepts a new request exactly like IDLE so results can stream
    // back-to-back; requests seen during RUN are dropped, not queued.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == n_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start && armed) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulator: after j steps acc = 1+2+...+j, so when cnt reaches n_reg
    // the running sum already equals the triangular number of the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= '0;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            n_reg <= N;
            cnt   <= '0;
            acc   <= '0;
        end else if ((state == RUN) && !finish) begin
            cnt   <= cnt + N_BITS'(1);
            acc   <= acc + W_BITS'(cnt) + W_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg <= '0;
        end else if (finish) begin
            w_reg <= acc;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign W    = w_reg;

endmodule : dec_lut_encoder8bits_clk

// File: tb/tb_dec_lut_encoder8bits_clk.sv
// -----------------------------------------------------------------------------
// tb_dec_lut_encoder8bits_clk
// Self-checking bench for dec_lut_encoder8bits_clk: a constant vector table,
// random indices checked against the closed-form triangular number, the
// reset/abort, ignored-request and back-to-back sequences, and a loopback
// through a behavioural 8-bit decoder for indices 0..255.
// -----------------------------------------------------------------------------
module tb_dec_lut_encoder8bits_clk;

    localparam int WB = 20;
    localparam int NB = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] N;
    logic          busy;
    logic          done;
    logic [WB-1:0] W;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dec_lut_encoder8bits_clk #(
        .W_BITS(WB),
        .N_BITS(NB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .N    (N),
        .busy (busy),
        .done (done),
        .W    (W)
    );

    typedef struct {
        int n;
        int exp_w;
    } vec_t;

    vec_t tbl[10];

    // Closed-form triangular number.
    function automatic longint tri_ref(input int n);
        return (longint'(n) * (longint'(n) + 1)) / 2;
    endfunction

    // Behavioural 8-bit LUT decoder: finds the index whose triangular number
    // equals the codeword.
    function automatic int decode_ref(input longint w, output bit found);
        found = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (tri_ref(k) == w) begin
                found = 1'b1;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issues one request with index n and follows it to its done pulse.
    task automatic run_encode(input int n, input string tag, output int lat);
        logic [WB-1:0] w_before;
        bit            busy_ok;
        bit            w_stable;
        @(negedge clk);
        start    = 1'b1;
        N        = NB'(n);
        w_before = W;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        N        = NB'($urandom);
        busy_ok  = busy && !done;
        w_stable = 1'b1;
        lat      = -1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!busy || done) busy_ok = 1'b0;
            if (W != w_before) w_stable = 1'b0;
        end
        check({tag, "_latency"}, lat, n + 1);
        check({tag, "_busy_during_run"}, busy_ok, 1);
        check({tag, "_w_held_during_run"}, w_stable, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_w"}, W, tri_ref(n));
    endtask

    initial begin
        int  lat;
        int  c1;
        int  c2;
        int  ndone;
        int  dec_n;
        bit  found;
        bit  no_idle;

        tbl[0] = '{0, 0};
        tbl[1] = '{1, 1};
        tbl[2] = '{2, 3};
        tbl[3] = '{3, 6};
        tbl[4] = '{4, 10};
        tbl[5] = '{10, 55};
        tbl[6] = '{100, 5050};
        tbl[7] = '{255, 32640};
        tbl[8] = '{256, 32896};
        tbl[9] = '{511, 130816};

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        N     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_w", W, 0);

        // Start held across the reset release edge must be ignored
        start = 1'b1;
        N     = NB'(5);
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_release_busy", busy, 0);
        @(negedge clk);
        check("start_at_release_busy_later", busy, 0);
        check("start_at_release_done", done, 0);

        // Vector table
        foreach (tbl[i]) begin
            run_encode(tbl[i].n, $sformatf("tbl%0d", i), lat);
            check($sformatf("tbl%0d_const", i), W, tbl[i].exp_w);
        end

        // Ignored request mid-run: N=10, start pulsed with N=3
        @(negedge clk);
        start = 1'b1;
        N     = NB'(10);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 4) begin
                start = 1'b1;
                N     = NB'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check("ignored_start_latency", lat, 11);
        check("ignored_start_w", W, 55);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("ignored_start_no_second_result", ndone, 0);
        check("ignored_start_w_held", W, 55);

        // Reset aborting a run
        @(negedge clk);
        start = 1'b1;
        N     = NB'(100);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_w", W, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done_after_release", done, 0);
        run_encode(4, "after_abort", lat);

        // Back-to-back: start held with N=2, then N=3 accepted from DONE
        @(negedge clk);
        start   = 1'b1;
        N       = NB'(2);
        @(posedge clk);
        c1      = -1;
        c2      = -1;
        no_idle = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c1 < 0 && done) begin
                c1 = c;
                check("b2b_first_w", W, 3);
                N = NB'(3);
            end else if (c1 > 0 && c == c1 + 1) begin
                if (!busy) no_idle = 1'b0;
                start = 1'b0;
            end else if (c1 > 0 && done) begin
                c2 = c;
                break;
            end
        end
        start = 1'b0;
        check("b2b_first_latency", c1, 3);
        check("b2b_no_idle_cycle", no_idle, 1);
        check("b2b_second_latency", c2 - c1 - 1, 4);
        check("b2b_second_w", W, 6);

        // Random indices against the closed-form model
        for (int i = 0; i < 20; i++) begin
            run_encode(int'($urandom_range(0, 511)), $sformatf("rand%0d", i), lat);
        end

        // Loopback through the behavioural decoder
        for (int k = 0; k < 256; k++) begin
            run_encode(k, $sformatf("loop%0d", k), lat);
            dec_n = decode_ref(longint'(W), found);
            check($sformatf("loop%0d_found", k), found, 1);
            check($sformatf("loop%0d_index", k), dec_n, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dec_lut_encoder8bits_clk
